// File: rtl/multi_rate_tick_gen.sv
// rtl/multi_rate_tick_gen.sv - multi-channel programmable tick and square-wave generator
// Define TICKGEN_CASCADE_EN to let channel i>0 count tick[i-1] instead of the timebase.
module multi_rate_tick_gen #(
  parameter int NUM_CH  = 6,
  parameter int CNT_W   = 32,
  parameter int DEF_DIV = 20000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clear,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_casc,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic              cfg_err
);

  localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [4:0]       NUM_CH_C  = 5'(NUM_CH);

  logic [NUM_CH-1:0][CNT_W-1:0] div_q, div_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            tick_q, tick_d;
  logic [NUM_CH-1:0]            sq_q, sq_d;
  logic [NUM_CH-1:0]            src_ev;
  logic [NUM_CH-1:0]            wr_sel;
  logic                         cfg_hit;
  logic                         cfg_err_q, cfg_err_d;

  // Out-of-range channel writes are dropped and only flagged.
  assign cfg_hit   = cfg_we && ({1'b0, cfg_ch} < NUM_CH_C);
  assign cfg_err_d = cfg_we && !cfg_hit;

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = cfg_hit && (cfg_ch == 4'(i));
    end
  end

`ifdef TICKGEN_CASCADE_EN
  logic [NUM_CH-1:0] casc_q, casc_d;
  logic              unused_casc0;

  // Channel 0 has no upstream tick, so its cascade bit is stored but never used.
  assign unused_casc0 = casc_q[0];

  always_comb begin
    casc_d = casc_q;
    src_ev = ch_en;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_sel[i]) casc_d[i] = cfg_casc;
    end
    for (int i = 1; i < NUM_CH; i++) begin
      if (casc_q[i]) src_ev[i] = ch_en[i] && tick_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      casc_q <= '0;
    end else begin
      casc_q <= casc_d;
    end
  end
`else
  logic unused_casc;

  assign unused_casc = cfg_casc;
  assign src_ev      = ch_en;
`endif

  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    tick_d = '0;
    sq_d   = sq_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_sel[i]) div_d[i] = cfg_div;
      if (sync_clear) begin
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
      end else if (wr_sel[i]) begin
        cnt_d[i] = '0;
      end else if (src_ev[i] && (div_q[i] != '0)) begin
        // >= keeps the counter bounded even if it were ever above div-1.
        if (cnt_q[i] >= (div_q[i] - ONE_C)) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          sq_d[i]   = ~sq_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + ONE_C;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= {NUM_CH{DEF_DIV_C}};
      cnt_q     <= '0;
      tick_q    <= '0;
      sq_q      <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign tick    = tick_q;
  assign sq      = sq_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// tb/tb_multi_rate_tick_gen.sv - directed vector bench for multi_rate_tick_gen
// Six channels, 8-bit counters, reset divisor 4.
module tb_multi_rate_tick_gen;

  localparam int NUM_CH = 6;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] ch_en;
  logic              sync_clear;
  logic              cfg_we;
  logic [3:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_casc;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic              cfg_err;

  multi_rate_tick_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(4)) dut (
    .clk(clk), .reset(reset), .ch_en(ch_en), .sync_clear(sync_clear),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_casc(cfg_casc),
    .tick(tick), .sq(sq), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] en;
    logic       sc;
    logic       we;
    logic [3:0] ch;
    logic [7:0] dv;
    logic [5:0] tk;
    logic [5:0] sq;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic add(input logic [5:0] en, input logic sc, input logic we,
                     input logic [3:0] ch, input logic [7:0] dv,
                     input logic [5:0] tk, input logic [5:0] sqv, input logic err);
    vec_t v;
    v.en = en; v.sc = sc; v.we = we; v.ch = ch; v.dv = dv;
    v.tk = tk; v.sq = sqv; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [5:0] en, input logic sc, input logic we,
                       input logic [3:0] ch, input logic [7:0] dv, input logic casc);
    ch_en = en; sync_clear = sc; cfg_we = we; cfg_ch = ch; cfg_div = dv; cfg_casc = casc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

`ifdef TICKGEN_CASCADE_EN
  int   t1[$];
  logic p0;
  logic skew_ok;
`endif

  initial begin
    reset = 1'b1;
    drive(6'h3F, 0, 0, 0, 0, 0);
    step(); step();
    chk("rst_state", 32'({tick, sq, cfg_err}), 0);
    reset = 1'b0;

    // Edge-by-edge vectors after release; expected outputs follow each edge.
    add(6'h3F,0,0,0,0, 6'h00,6'h00,0); // 1
    add(6'h3F,0,0,0,0, 6'h00,6'h00,0);
    add(6'h3F,0,0,0,0, 6'h00,6'h00,0);
    add(6'h3F,0,0,0,0, 6'h3F,6'h3F,0); // 4: first tick
    add(6'h3F,0,0,0,0, 6'h00,6'h3F,0);
    add(6'h3F,0,0,0,0, 6'h00,6'h3F,0);
    add(6'h3F,0,0,0,0, 6'h00,6'h3F,0);
    add(6'h3F,0,0,0,0, 6'h3F,6'h00,0); // 8
    add(6'h3E,0,0,0,0, 6'h00,6'h00,0); // 9: ch0 paused
    add(6'h3E,0,0,0,0, 6'h00,6'h00,0);
    add(6'h3F,0,0,0,0, 6'h00,6'h00,0);
    add(6'h3F,0,0,0,0, 6'h3E,6'h3E,0); // 12
    add(6'h3F,0,0,0,0, 6'h00,6'h3E,0);
    add(6'h3F,0,0,0,0, 6'h01,6'h3F,0); // 14: ch0 lags by 2
    add(6'h3F,0,1,2,3, 6'h00,6'h3F,0); // 15: ch2 div=3 mid-count
    add(6'h3F,0,0,0,0, 6'h3A,6'h05,0);
    add(6'h3F,0,0,0,0, 6'h00,6'h05,0);
    add(6'h3F,0,0,0,0, 6'h05,6'h00,0); // 18: ch2 three edges after write
    add(6'h3F,0,1,15,1, 6'h00,6'h00,1); // 19: bad channel
    add(6'h3F,0,0,0,0, 6'h3A,6'h3A,0);
    add(6'h3F,0,0,0,0, 6'h04,6'h3E,0);
    add(6'h3F,0,0,0,0, 6'h01,6'h3F,0);
    add(6'h3F,1,1,0,2, 6'h00,6'h00,0); // 23: sync_clear + ch0 div=2
    add(6'h3F,0,0,0,0, 6'h00,6'h00,0);
    add(6'h3F,0,0,0,0, 6'h01,6'h01,0);
    add(6'h3F,0,0,0,0, 6'h04,6'h05,0);
    add(6'h3F,0,0,0,0, 6'h3B,6'h3E,0); // 27

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].sc, vecs[i].we, vecs[i].ch, vecs[i].dv, 0);
      step();
      chk($sformatf("vec%0d tick/sq/err", i + 1), 32'({tick, sq, cfg_err}),
          32'({vecs[i].tk, vecs[i].sq, vecs[i].err}));
    end

    // ch1 (sq=1 here): div=0 halts, div=1 ticks continuously, ch_en gating.
    drive(6'h3F, 0, 1, 1, 0, 0);
    step();
    chk("div0_write", 32'({tick[1], sq[1]}), 32'b01);
    drive(6'h3F, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("div0_hold%0d", k), 32'({tick[1], sq[1]}), 32'b01);
    end
    drive(6'h3F, 0, 1, 1, 1, 0);
    step();
    chk("div1_write", 32'({tick[1], sq[1], cfg_err}), 32'b010);
    drive(6'h3F, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("div1_run%0d", k), 32'({tick[1], sq[1]}), 32'({1'b1, k[0]}));
    end
    drive(6'h3D, 0, 0, 0, 0, 0);
    step();
    chk("en_off", 32'({tick[1], sq[1]}), 32'b01);
    drive(6'h3F, 0, 0, 0, 0, 0);
    step();
    chk("en_on", 32'({tick[1], sq[1]}), 32'b10);

    // Asynchronous reset mid-period, then restart from the reset divisor.
    #3;
    reset = 1'b1;
    #1;
    chk("rst_async", 32'({tick, sq, cfg_err}), 0);
    step(); step();
    chk("rst_held", 32'({tick, sq, cfg_err}), 0);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("rst_restart%0d", k), 32'({tick, sq}),
          (k == 4) ? 32'({6'h3F, 6'h3F}) : 32'd0);
    end

`ifdef TICKGEN_CASCADE_EN
    drive(6'h3F, 1, 1, 1, 15, 1);
    step();
    drive(6'h3F, 0, 0, 0, 0, 0);
    p0 = 1'b0;
    skew_ok = 1'b1;
    for (int c = 0; c < 200 && t1.size() < 2; c++) begin
      step();
      if (tick[1]) begin
        t1.push_back(c);
        if (!p0) skew_ok = 1'b0;
      end
      p0 = tick[0];
    end
    chk("casc_seen", 32'(t1.size()), 2);
    if (t1.size() == 2) chk("casc_period", 32'(t1[1] - t1[0]), 60);
    chk("casc_skew", 32'(skew_ok), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
